// File: rtl/aes_pkg.sv
// Shared AES helpers for the sequential round coprocessors:
// the FSM state encoding, the fn bit that selects mixing, and the GF(2^8) xtime.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned FN_MIX = 0;
  localparam logic [7:0] GF_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: one purely combinational 8-bit lookup.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/dec1s_seq.sv
// Multi-cycle AES decrypt helper: InvSubBytes one byte per cycle through a shared
// inverse S-box, optional InvMixColumns, XOR into rs1, result over valid/ready.
module dec1s_seq
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_fn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rd,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] src_q, src_d;
  logic [31:0] rd_q, rd_d;
  logic        mode_q, mode_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic [7:0]  sb_in_s;
  logic [7:0]  sb_out_s;
  logic [31:0] term_s;
  logic        fn_unused_s;

  // InvMixColumns contribution of a single nonzero byte, packed {0b,0d,09,0e}*s.
  function automatic logic [31:0] inv_mix_col(input logic [7:0] s);
    logic [7:0] x2, x4, x8;
    x2 = xtime(s);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x2 ^ s, x8 ^ x4 ^ s, x8 ^ s, x8 ^ x4 ^ x2};
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = w;
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      2'd3:    r = {w[7:0],  w[31:8]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign fn_unused_s = ^in_fn[4:1];

  aes_inv_sbox u_inv_sbox (
    .in_byte  (sb_in_s),
    .out_byte (sb_out_s)
  );

  // Byte lane selection and the rotated contribution of the current lane.
  always_comb begin
    case (cnt_q)
      2'd0:    sb_in_s = src_q[7:0];
      2'd1:    sb_in_s = src_q[15:8];
      2'd2:    sb_in_s = src_q[23:16];
      2'd3:    sb_in_s = src_q[31:24];
      default: sb_in_s = src_q[7:0];
    endcase
    if (mode_q) begin
      term_s = rotl_bytes(inv_mix_col(sb_out_s), cnt_q);
    end else begin
      term_s = rotl_bytes({24'h000000, sb_out_s}, cnt_q);
    end
  end

  // Next-state logic for the FSM and its datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    src_d   = src_q;
    rd_d    = rd_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          acc_d   = in_rs1;
          src_d   = in_rs2;
          mode_d  = in_fn[FN_MIX];
          cnt_d   = 2'd0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_q ^ term_s;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = ST_DONE;
          rd_d    = acc_q ^ term_s;
          valid_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      acc_q   <= 32'h00000000;
      src_q   <= 32'h00000000;
      rd_q    <= 32'h00000000;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      src_q   <= src_d;
      rd_q    <= rd_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = valid_q;
  assign out_rd    = rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dec1s_seq.sv
// Self-checking bench for dec1s_seq: an abstract transaction model (S-box derived from
// GF inverses, generic GF multiply) checked every cycle, plus directed literal cases.
module tb_dec1s_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_fn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rd;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] invs [0:255];

  // Model state: one transaction in flight, result visible after four working cycles.
  logic        m_idle;
  logic        m_done;
  int          m_left;
  logic [31:0] m_res;
  logic [31:0] m_rd;

  dec1s_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_fn     (in_fn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] model_op(input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic [4:0] fn);
    logic [31:0] r, col;
    logic [7:0]  s;
    r = rs1;
    for (int i = 0; i < 4; i++) begin
      s = invs[rs2[8*i +: 8]];
      if (fn[0]) col = {gmul(8'h0b, s), gmul(8'h0d, s), gmul(8'h09, s), gmul(8'h0e, s)};
      else       col = {24'h000000, s};
      r = r ^ ((col << (8*i)) | (i == 0 ? 32'h0 : (col >> (32 - 8*i))));
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= 32'h0;
      m_rd   <= 32'h0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_res  <= model_op(in_rs1, in_rs2, in_fn);
        m_idle <= 1'b0;
        m_left <= 4;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_rd   <= m_res;
      end
    end else if (m_done && out_ready) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare every output against the model at the falling edge.
  task automatic tick();
    @(negedge clk);
    check("in_ready",  {31'd0, in_ready},  {31'd0, m_idle});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_done});
    check("busy",      {31'd0, busy},      {31'd0, ~m_idle});
    check("out_rd",    out_rd,             m_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!m_idle && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, m_idle}, 32'd1);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 32'd4);
    check({name, "_rd"}, out_rd, exp);
  endtask

  task automatic op(input string name, input logic [31:0] r1, input logic [31:0] r2,
                    input logic [4:0] f, input logic [31:0] exp);
    wait_idle();
    in_valid  = 1'b1;
    in_rs1    = r1;
    in_rs2    = r2;
    in_fn     = f;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(name, exp);
    tick();
  endtask

  initial begin
    int n;
    logic [7:0] b, sfw;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(x[7:0], y[7:0]) == 8'h01) b = y[7:0];
      sfw = b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
      invs[sfw] = x[7:0];
    end

    rst_n = 1'b0; in_valid = 1'b0; in_rs1 = 32'h0; in_rs2 = 32'h0;
    in_fn = 5'h00; out_ready = 1'b1;

    check("model_invs00", {24'd0, invs[8'h00]}, 32'h52);
    check("model_invs63", {24'd0, invs[8'h63]}, 32'h00);
    check("model_invsff", {24'd0, invs[8'hff]}, 32'h7d);
    check("model_sub",   model_op(32'h0, 32'h7c630100, 5'h00), 32'h01000952);
    check("model_mix0",  model_op(32'hffffffff, 32'h6363637c, 5'h01), 32'hf4f2f6f1);
    check("model_mix1",  model_op(32'h0, 32'h63637c63, 5'h1f), 32'h0d090e0b);

    repeat (3) tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_out_rd",    out_rd,             32'h0);
    rst_n = 1'b1;
    tick();

    op("sub",  32'h00000000, 32'h7c630100, 5'h00, 32'h01000952);
    op("mix0", 32'hffffffff, 32'h6363637c, 5'h01, 32'hf4f2f6f1);
    op("mix1", 32'h00000000, 32'h63637c63, 5'h1f, 32'h0d090e0b);

    // Back-to-back requests: ready returns five edges after the accepting edge.
    wait_idle();
    in_valid = 1'b1; in_rs1 = 32'h12345678; in_rs2 = 32'h9abcdef0; in_fn = 5'h01;
    tick();
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("thru_gap", n, 32'd5);
    in_valid = 1'b0;
    wait_idle();

    // Backpressure in DONE with new requests and changing operands offered.
    in_valid = 1'b1; in_rs1 = 32'h0; in_rs2 = 32'h7c630100; in_fn = 5'h00; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid("bp", 32'h01000952);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rs1 = $urandom; in_rs2 = $urandom; in_fn = 5'($urandom);
      tick();
      check("bp_hold_rd",    out_rd,             32'h01000952);
      check("bp_hold_ready", {31'd0, in_ready},  32'd0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    in_rs1 = 32'h0; in_rs2 = 32'h63637c63; in_fn = 5'h01; out_ready = 1'b1;
    tick();
    check("bp_release_ready", {31'd0, in_ready},  32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("bp_next_accept", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_valid("bp_next", 32'h0d090e0b);
    tick();

    // Reset while the byte counter sits at 2.
    wait_idle();
    in_valid = 1'b1; in_rs1 = 32'h0; in_rs2 = 32'h7c630100; in_fn = 5'h00;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy",  {31'd0, busy},      32'd0);
    check("abort_ready", {31'd0, in_ready},  32'd1);
    check("abort_rd",    out_rd,             32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    op("after_abort", 32'h00000000, 32'h7c630100, 5'h00, 32'h01000952);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_rs1    = $urandom;
      in_rs2    = $urandom;
      in_fn     = 5'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
